gf163_reduce: RTL and testbench

GF163_REDUCE -- requirements
Module: gf163_reduce

---
 rtl/gf163_reduce.sv | 116 +++++++++++
 tb/tb_gf163_reduce.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf163_reduce.sv
// Reduces a 325-bit unreduced GF(2) product modulo f(x) = x^163 + x^7 + x^6 + x^3 + 1, using two registered folds.
// Latency: out_valid rises 3 cycles after accept, or 2 when GF163_RED_EARLY_EXIT_EN is defined and the second fold is not needed.
// Backpressure: holds the result until out_ready; in_ready is low while folding and follows out_ready in HOLD.
module gf163_reduce (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [324:0] in_prod,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [162:0] out_res,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, FOLD1, FOLD2, HOLD} state_t;

   state_t        state;
   state_t        state_nxt;

   logic [324:0]  prod_q;
   logic [169:0]  r1_q;
   logic [162:0]  res_q;

   logic [161:0]  h;
   logic [169:0]  r1_c;
   logic [6:0]    h2;
   logic [162:0]  res_c;
   logic          accept;
   logic          early_exit;

   // First fold: x^163 == x^7 + x^6 + x^3 + 1, so the upper 162 bits fold back onto the lower half.
   // The result can spill up to 7 bits past x^162.
   always_comb begin
      h    = prod_q[324:163];
      r1_c = {7'd0, prod_q[162:0]}
           ^ {8'd0, h}
           ^ {5'd0, h, 3'd0}
           ^ {2'd0, h, 6'd0}
           ^ {1'd0, h, 7'd0};
   end

   // Second fold: the 7 spill bits shifted by at most 7 reach degree 13 at most, so nothing is lost.
   always_comb begin
      h2    = r1_q[169:163];
      res_c = r1_q[162:0]
            ^ {156'd0, h2}
            ^ {153'd0, h2, 3'd0}
            ^ {150'd0, h2, 6'd0}
            ^ {149'd0, h2, 7'd0};
   end

`ifdef GF163_RED_EARLY_EXIT_EN
   // When the first fold leaves no spill bits, its low 163 bits are already the final result.
   assign early_exit = (r1_c[169:163] == 7'd0);
`else
   assign early_exit = 1'b0;
`endif

   // State register; reset aborts any in-flight transaction.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; a retire in HOLD can accept the next product on the same edge.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = FOLD1;
         FOLD1:   state_nxt = early_exit ? HOLD : FOLD2;
         FOLD2:   state_nxt = HOLD;
         HOLD:    if (out_ready) state_nxt = in_valid ? FOLD1 : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake and status outputs decoded from the state.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE:    in_ready = 1'b1;
         HOLD:    begin
                     in_ready  = out_ready;
                     out_valid = 1'b1;
                  end
         default: in_ready = 1'b0;
      endcase
   end

   assign accept = in_valid && in_ready;

   // Datapath registers: the product is sampled only on an accept, and each fold updates only in its own state.
   always_ff @(posedge clk) begin
      if (rst) begin
         prod_q <= '0;
         r1_q   <= '0;
         res_q  <= '0;
      end else begin
         if (accept)
            prod_q <= in_prod;
         if (state == FOLD1) begin
            r1_q <= r1_c;
            if (early_exit)
               res_q <= r1_c[162:0];
         end
         if (state == FOLD2)
            res_q <= res_c;
      end
   end

   assign out_res = res_q;

endmodule

// File: tb/tb_gf163_reduce.sv
module tb_gf163_reduce;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [324:0] in_prod;
   logic         out_valid;
   logic         out_ready;
   logic [162:0] out_res;
   logic         busy;

   int vectors     = 0;
   int miscompares = 0;

`ifdef GF163_RED_EARLY_EXIT_EN
   localparam int SHORT_LAT = 2;
`else
   localparam int SHORT_LAT = 3;
`endif
   localparam int LONG_LAT = 3;
   localparam int N_RAND   = 10000;

   gf163_reduce dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_prod   (in_prod),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Long-division reference: clears each bit at or above x^163 with a shifted copy of f(x).
   function automatic logic [162:0] ref_mod(input logic [324:0] p);
      logic [324:0] t;
      logic [324:0] f;
      f = '0;
      f[163] = 1'b1;
      f[7] = 1'b1;
      f[6] = 1'b1;
      f[3] = 1'b1;
      f[0] = 1'b1;
      t = p;
      for (int i = 324; i >= 163; i--)
         if (t[i]) t = t ^ (f << (i - 163));
      return t[162:0];
   endfunction

   function automatic logic [324:0] rand_prod();
      logic [324:0] p;
      p = '0;
      for (int i = 0; i < 11; i++)
         p = (p << 32) | 325'($urandom());
      return p;
   endfunction

   // Runs one transaction from IDLE; reports the result and the edge count from accept to out_valid.
   task automatic xact(input logic [324:0] p, output logic [162:0] res, output int lat);
      in_prod   = p;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      res = out_res;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_prod = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_res !== 163'd0) begin
         miscompares++;
         $display("FAIL reset: in_ready=%b out_valid=%b busy=%b out_res=%h, expected 1 0 0 0",
                  in_ready, out_valid, busy, out_res);
      end
   endtask

   task automatic test_one();
      logic [162:0] res; int lat;
      xact(325'd1, res, lat);
      vectors++;
      if (res !== 163'd1 || lat != SHORT_LAT) begin
         miscompares++;
         $display("FAIL one: out_res=%h lat=%0d, expected 1 lat=%0d", res, lat, SHORT_LAT);
      end
   endtask

   task automatic test_x163();
      logic [324:0] p; logic [162:0] res; int lat;
      p = '0; p[163] = 1'b1;
      xact(p, res, lat);
      vectors++;
      if (res !== 163'hC9 || lat != SHORT_LAT) begin
         miscompares++;
         $display("FAIL x163: out_res=%h lat=%0d, expected c9 lat=%0d", res, lat, SHORT_LAT);
      end
   endtask

   task automatic test_x324();
      logic [324:0] p; logic [162:0] exp; logic [162:0] res; int lat;
      p = '0; p[324] = 1'b1;
      exp = 163'h1422; exp[161] = 1'b1;
      xact(p, res, lat);
      vectors++;
      if (res !== exp || lat != LONG_LAT) begin
         miscompares++;
         $display("FAIL x324: out_res=%h lat=%0d, expected %h lat=%0d", res, lat, exp, LONG_LAT);
      end
      vectors++;
      if (ref_mod(p) !== exp) begin
         miscompares++;
         $display("FAIL x324_model: model=%h, expected %h", ref_mod(p), exp);
      end
   endtask

   task automatic test_passthrough();
      logic [324:0] p; logic [162:0] res; int lat;
      for (int k = 0; k < 3; k++) begin
         p = rand_prod();
         p[324:163] = '0;
         xact(p, res, lat);
         vectors++;
         if (res !== p[162:0]) begin
            miscompares++;
            $display("FAIL passthrough: out_res=%h, expected %h", res, p[162:0]);
         end
      end
   endtask

   task automatic test_stall();
      logic [324:0] p1; logic [324:0] p2; int n;
      p1 = rand_prod(); p2 = rand_prod();
      in_prod = p1; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
      for (int c = 0; c < 5; c++) begin
         vectors++;
         if (out_valid !== 1'b1 || out_res !== ref_mod(p1) || in_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_hold: cyc=%0d out_valid=%b in_ready=%b busy=%b out_res=%h, expected 1 0 1 %h",
                     c, out_valid, in_ready, busy, out_res, ref_mod(p1));
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1; in_valid = 1'b1; in_prod = p2;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL stall_release_ready: in_ready=%b, expected 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL stall_same_edge: out_valid=%b busy=%b in_ready=%b, expected 0 1 0",
                  out_valid, busy, in_ready);
      end
      n = 1;
      while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
      vectors++;
      if (out_res !== ref_mod(p2) || n != LONG_LAT) begin
         miscompares++;
         $display("FAIL stall_second: out_res=%h lat=%0d, expected %h lat=%0d", out_res, n, ref_mod(p2), LONG_LAT);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_abort();
      logic seen;
      in_prod = '1; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_res !== 163'd0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_state: in_ready=%b out_valid=%b busy=%b out_res=%h, expected 1 0 0 0",
                  in_ready, out_valid, busy, out_res);
      end
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (out_valid) seen = 1'b1;
         @(posedge clk); #1;
      end
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_no_output: out_valid seen=%b, expected 0", seen);
      end
      // Reset asserted together with an offered product: the product must be dropped.
      rst = 1'b1; in_valid = 1'b1; in_prod = '1;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      seen = busy;
      for (int c = 0; c < 5; c++) begin
         if (out_valid || busy) seen = 1'b1;
         @(posedge clk); #1;
      end
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_dominates: busy/out_valid seen=%b, expected 0", seen);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [162:0] sb[$]; logic [162:0] exp; logic [324:0] p; int sent; int got; int cyc;
      sent = 0; got = 0; cyc = 0;
      while (got < N_RAND && cyc < 80000) begin
         in_valid = (sent < N_RAND) && ($urandom_range(7) != 0);
         p = rand_prod();
         if ($urandom_range(15) == 0) p[324:163] = '0;
         in_prod = p;
         out_ready = ($urandom_range(3) != 0);
         #1;
         if (out_valid && out_ready) begin
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL stream_extra: out_res=%h, expected no output", out_res);
            end else begin
               exp = sb.pop_front();
               if (out_res !== exp) begin
                  miscompares++;
                  $display("FAIL stream_data: idx=%0d out_res=%h, expected %h", got, out_res, exp);
               end
            end
            got++;
         end
         if (in_valid && in_ready) begin
            sb.push_back(ref_mod(p));
            sent++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      vectors++;
      if (got != N_RAND || sb.size() != 0) begin
         miscompares++;
         $display("FAIL stream_count: retired=%0d pending=%0d, expected %0d and 0", got, sb.size(), N_RAND);
      end
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_prod = '0;
      @(posedge clk); #1;
      test_reset();
      test_one();
      test_x163();
      test_x324();
      test_passthrough();
      test_stall();
      test_abort();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
